// File: rtl/sum_accumulator_pkg.sv
// Shared types and default widths for the sum_accumulator block.
// Used by both the handshake interface and the accumulator itself.
package sum_accumulator_pkg;

  localparam int DEF_IN_W        = 2;
  localparam int DEF_ACC_W       = 8;
  localparam int DEF_NUM_SAMPLES = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    HOLD
  } state_t;

endpackage

// File: rtl/sum_accumulator_if.sv
// Valid/ready handshake bundle for the sum_accumulator: sample input side,
// flush control and the window-total output side.
interface sum_accumulator_if #(
  parameter int IN_W  = 2,
  parameter int ACC_W = 8
);

  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  logic [ACC_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             ovf;

  // Environment side: supplies samples and consumes window totals.
  modport master (
    output in_data, in_valid, flush, out_ready,
    input  in_ready, out_data, out_valid, ovf
  );

  modport slave (
    input  in_data, in_valid, flush, out_ready,
    output in_ready, out_data, out_valid, ovf
  );

endinterface

// File: rtl/sum_accumulator.sv
// Adds NUM_SAMPLES incoming sums per window and holds the total until taken.
// Define SUM_ACCUMULATOR_SAT_EN for saturating arithmetic with a sticky ovf flag.
module sum_accumulator
  import sum_accumulator_pkg::*;
#(
  parameter int IN_W        = DEF_IN_W,
  parameter int ACC_W       = DEF_ACC_W,
  parameter int NUM_SAMPLES = DEF_NUM_SAMPLES
) (
  input  logic               clk,
  input  logic               rst,
  sum_accumulator_if.slave   bus
);

  localparam int CNT_W = $clog2(NUM_SAMPLES + 1);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] out_data_q;
  logic             out_valid_q;
  logic [IN_W-1:0]  in_sample;
  logic             accept;
  logic             last;
  logic             window_clear;

  assign in_sample    = bus.in_data;
  assign bus.in_ready = (state != HOLD);
  assign accept       = bus.in_valid & bus.in_ready;
  assign last         = (cnt == CNT_W'(NUM_SAMPLES - 1));
  // Flush outside HOLD or a completed handoff both start a fresh window.
  assign window_clear = (state != HOLD) ? bus.flush : bus.out_ready;

`ifdef SUM_ACCUMULATOR_SAT_EN
  logic [ACC_W:0] sum_wide;
  logic           sat_seen;
  logic           sat_next;
  logic           ovf_q;

  assign sum_wide = {1'b0, acc} + (ACC_W + 1)'(in_sample);
  assign sat_next = sat_seen | sum_wide[ACC_W];
  assign acc_next = sat_next ? '1 : sum_wide[ACC_W-1:0];
  assign bus.ovf  = ovf_q;

  always_ff @(posedge clk) begin
    if (rst || window_clear) begin
      sat_seen <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      sat_seen <= sat_next;
      if (last) ovf_q <= sat_next;
    end
  end
`else
  assign acc_next = acc + ACC_W'(in_sample);
  assign bus.ovf  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst || window_clear) cnt <= '0;
    else if (accept)         cnt <= cnt + CNT_W'(1);
  end

  // NOTE: state registers use non-blocking assignments so every register in
  // the block samples pre-edge values; blocking here would create order races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE, ACC: begin
          if (bus.flush) begin
            state <= IDLE;
            acc   <= '0;
          end else if (accept) begin
            acc <= acc_next;
            if (last) begin
              state       <= HOLD;
              out_data_q  <= acc_next;
              out_valid_q <= 1'b1;
            end else begin
              state <= ACC;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            acc         <= '0;
            out_valid_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed self-checking bench for sum_accumulator: default, narrow/long,
// and single-sample windows, with flush, backpressure and reset cases.
module tb_sum_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

`ifdef SUM_ACCUMULATOR_SAT_EN
  localparam int EXP_NARROW     = 15;
  localparam int EXP_NARROW_OVF = 1;
`else
  localparam int EXP_NARROW     = 2;
  localparam int EXP_NARROW_OVF = 0;
`endif

  always #5 clk = ~clk;

  sum_accumulator_if #(.IN_W(2), .ACC_W(8)) bus ();
  sum_accumulator_if #(.IN_W(2), .ACC_W(4)) bus_n ();
  sum_accumulator_if #(.IN_W(2), .ACC_W(8)) bus_1 ();

  sum_accumulator #(.IN_W(2), .ACC_W(8), .NUM_SAMPLES(4)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  sum_accumulator #(.IN_W(2), .ACC_W(4), .NUM_SAMPLES(6)) dut_n (
    .clk(clk), .rst(rst), .bus(bus_n)
  );
  sum_accumulator #(.IN_W(2), .ACC_W(8), .NUM_SAMPLES(1)) dut_1 (
    .clk(clk), .rst(rst), .bus(bus_1)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs and samples both live 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic send_n(input logic [1:0] d);
    bus_n.in_valid = 1'b1;
    bus_n.in_data  = d;
    tick();
    bus_n.in_valid = 1'b0;
  endtask

  task automatic handoff();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.in_data = '0;   bus.in_valid = 0;   bus.flush = 0;   bus.out_ready = 0;
    bus_n.in_data = '0; bus_n.in_valid = 0; bus_n.flush = 0; bus_n.out_ready = 0;
    bus_1.in_data = '0; bus_1.in_valid = 0; bus_1.flush = 0; bus_1.out_ready = 0;

    repeat (2) tick();
    rst = 1'b0;
    check("reset_out_valid", int'(bus.out_valid), 0);
    check("reset_out_data", int'(bus.out_data), 0);
    check("reset_ovf", int'(bus.ovf), 0);
    check("reset_in_ready", int'(bus.in_ready), 1);

    // Window 3,2,1,3 back to back.
    send(2'd3); send(2'd2); send(2'd1);
    check("t1_not_early", int'(bus.out_valid), 0);
    send(2'd3);
    check("t1_out_valid", int'(bus.out_valid), 1);
    check("t1_out_data", int'(bus.out_data), 9);
    check("t1_ovf", int'(bus.ovf), 0);

    // Backpressure: result must hold while out_ready stays low.
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_hold_valid", int'(bus.out_valid), 1);
      check("t2_hold_data", int'(bus.out_data), 9);
      check("t2_hold_in_ready", int'(bus.in_ready), 0);
    end
    handoff();
    check("t2_handoff_valid", int'(bus.out_valid), 0);
    check("t2_handoff_in_ready", int'(bus.in_ready), 1);

    // Flush drops the partial window and the simultaneous sample.
    send(2'd3); send(2'd3);
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_data = 2'd2;
    tick();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    send(2'd1); send(2'd1); send(2'd1);
    check("t4_not_early", int'(bus.out_valid), 0);
    send(2'd1);
    check("t4_out_valid", int'(bus.out_valid), 1);
    check("t4_out_data", int'(bus.out_data), 4);

    // Sample offered during the handoff cycle is taken one cycle later.
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_data = 2'd2;
    tick();
    bus.out_ready = 1'b0;
    check("t6_released", int'(bus.out_valid), 0);
    check("t6_in_ready", int'(bus.in_ready), 1);
    tick();
    bus.in_valid = 1'b0;
    send(2'd1); send(2'd1);
    check("t6_not_early", int'(bus.out_valid), 0);
    send(2'd1);
    check("t6_out_valid", int'(bus.out_valid), 1);
    check("t6_out_data", int'(bus.out_data), 5);
    handoff();

    // Reset mid-handshake while holding 9.
    send(2'd3); send(2'd2); send(2'd1); send(2'd3);
    check("t5_pre_data", int'(bus.out_data), 9);
    rst = 1'b1; bus.out_ready = 1'b1;
    tick();
    rst = 1'b0; bus.out_ready = 1'b0;
    check("t5_out_valid", int'(bus.out_valid), 0);
    check("t5_out_data", int'(bus.out_data), 0);
    check("t5_in_ready", int'(bus.in_ready), 1);
    check("t5_ovf", int'(bus.ovf), 0);

    // Narrow accumulator: six samples of 3 into 4 bits.
    for (int i = 0; i < 5; i++) send_n(2'd3);
    check("t3_not_early", int'(bus_n.out_valid), 0);
    send_n(2'd3);
    check("t3_out_valid", int'(bus_n.out_valid), 1);
    check("t3_out_data", int'(bus_n.out_data), EXP_NARROW);
    check("t3_ovf", int'(bus_n.ovf), EXP_NARROW_OVF);
    bus_n.out_ready = 1'b1;
    tick();
    bus_n.out_ready = 1'b0;
    check("t3_ovf_cleared", int'(bus_n.ovf), 0);

    // Single-sample window goes straight from IDLE to HOLD.
    bus_1.in_valid = 1'b1; bus_1.in_data = 2'd3;
    tick();
    bus_1.in_valid = 1'b0;
    check("n1_out_valid", int'(bus_1.out_valid), 1);
    check("n1_out_data", int'(bus_1.out_data), 3);
    check("n1_in_ready", int'(bus_1.in_ready), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
